// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: state encodings and quick-start amount shared by timer_controller and its bench
package timer_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READY   = 2'd1,
      ST_RUNNING = 2'd2,
      ST_PAUSED  = 2'd3
   } state_t;
   localparam int QUICK_START_SEC = 30;
endpackage

// File: rtl/timer_controller_if.sv
// timer_controller_if: user/door inputs and countdown status outputs of timer_controller
interface timer_controller_if #(parameter int TIME_W = 8);
   logic              start;
   logic              stop;
   logic              door_closed;
   logic              time_load;
   logic [TIME_W-1:0] time_in;
   logic [TIME_W-1:0] remaining;
   logic              magnetron_on;
   logic              done;
   logic [1:0]        state;
   modport master (
      output start, stop, door_closed, time_load, time_in,
      input  remaining, magnetron_on, done, state
   );
   modport slave (
      input  start, stop, door_closed, time_load, time_in,
      output remaining, magnetron_on, done, state
   );
endinterface

// File: rtl/timer_controller_tick_prescaler.sv
// tick_prescaler: one-cycle tick every CLK_DIV enabled cycles; count holds while disabled
module tick_prescaler #(
   parameter int CLK_DIV = 100
) (
   input  logic clk,
   input  logic clear,
   input  logic enable,
   input  logic restart,
   output logic tick
);
   localparam int CNT_W = $clog2(CLK_DIV);
   logic [CNT_W-1:0] cnt;
   assign tick = enable && cnt == CNT_W'(CLK_DIV - 1);
   always_ff @(posedge clk or posedge clear)
      if (clear)
         cnt <= '0;
      else if (restart)
         cnt <= '0;
      else if (enable)
         cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/timer_controller.sv
// timer_controller: non-recycling countdown FSM with door interlock and done pulse.
// Define TIMER_CTRL_QUICK_START_EN to let start launch/extend a run by QUICK_START_SEC.
module timer_controller import timer_ctrl_pkg::*; #(
   parameter int CLK_DIV = 100,
   parameter int TIME_W  = 8
) (
   input logic               clk,
   input logic               clear,
   timer_controller_if.slave bus
);
   state_t            state_q, state_n;
   logic [TIME_W-1:0] rem_q, rem_n;
   logic              done_q, done_n;
   logic              restart, tick, run_en;
   assign run_en = state_q == ST_RUNNING && bus.door_closed && !bus.stop;
   tick_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (
      .clk     (clk),
      .clear   (clear),
      .enable  (run_en),
      .restart (restart),
      .tick    (tick)
   );
`ifdef TIMER_CTRL_QUICK_START_EN
   logic [TIME_W:0] sum;
   assign sum = {1'b0, rem_q} + (TIME_W+1)'(QUICK_START_SEC);
`endif
   always_ff @(posedge clk or posedge clear)
      if (clear) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         rem_q   <= rem_n;
         done_q  <= done_n;
      end
   always_comb begin
      state_n = state_q;
      rem_n   = rem_q;
      done_n  = 1'b0;
      restart = 1'b0;
      case (state_q)
         ST_IDLE:
            if (bus.stop)
               rem_n = '0;
            else if (bus.time_load) begin
               if (bus.time_in != '0) begin
                  state_n = ST_READY;
                  rem_n   = bus.time_in;
               end
            end
`ifdef TIMER_CTRL_QUICK_START_EN
            else if (bus.start && bus.door_closed) begin
               state_n = ST_RUNNING;
               rem_n   = TIME_W'(QUICK_START_SEC);
               restart = 1'b1;
            end
`endif
         ST_READY:
            if (bus.stop) begin
               state_n = ST_IDLE;
               rem_n   = '0;
            end else if (bus.time_load) begin
               state_n = bus.time_in == '0 ? ST_IDLE : ST_READY;
               rem_n   = bus.time_in;
            end else if (bus.start && bus.door_closed) begin
               state_n = ST_RUNNING;
               restart = 1'b1;
            end
         ST_RUNNING:
            if (bus.stop || !bus.door_closed)
               state_n = ST_PAUSED;
`ifdef TIMER_CTRL_QUICK_START_EN
            else if (bus.start)
               rem_n = sum[TIME_W] ? '1 : sum[TIME_W-1:0];
`endif
            else if (tick) begin
               // a tick at 1 (or a defensive 0) finishes the run instead of wrapping
               if (rem_q <= TIME_W'(1)) begin
                  state_n = ST_IDLE;
                  rem_n   = '0;
                  done_n  = 1'b1;
               end else
                  rem_n = rem_q - 1'b1;
            end
         ST_PAUSED:
            if (bus.stop) begin
               state_n = ST_IDLE;
               rem_n   = '0;
            end else if (bus.start && bus.door_closed)
               state_n = ST_RUNNING;
         default: begin
            state_n = ST_IDLE;
            rem_n   = '0;
         end
      endcase
   end
   assign bus.remaining    = rem_q;
   assign bus.done         = done_q;
   assign bus.state        = state_q;
   assign bus.magnetron_on = state_q == ST_RUNNING && bus.door_closed;
endmodule

// File: tb/tb_timer_controller.sv
// tb_timer_controller: vector table, directed corner sequences and randomized run against a seconds/cycles model
module tb_timer_controller;
   localparam int CLK_DIV = 4;
   localparam int QS      = 30;
   logic clk   = 1'b0;
   logic clear = 1'b1;
   always #5 clk = ~clk;
   timer_controller_if #(.TIME_W(8)) bus();
   timer_controller #(.CLK_DIV(CLK_DIV), .TIME_W(8)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );
   typedef struct {
      bit       st, sp, dc, ld;
      int       ti;
      int       est, erem;
      bit       edone;
   } vec_t;
   vec_t tbl[$];
   int n_cmp = 0;
   int n_err = 0;
   // model: remaining = credited seconds minus whole ticks elapsed in enabled running cycles
   int m_st, m_base, m_cyc;
   bit m_done;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit st, input bit sp, input bit dc, input bit ld, input int ti);
      bus.start       = st;
      bus.stop        = sp;
      bus.door_closed = dc;
      bus.time_load   = ld;
      bus.time_in     = 8'(ti);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input bit st, input bit sp, input bit dc, input bit ld, input int ti,
                          input int est, input int erem, input bit edone);
      vec_t v;
      v.st = st; v.sp = sp; v.dc = dc; v.ld = ld; v.ti = ti;
      v.est = est; v.erem = erem; v.edone = edone;
      tbl.push_back(v);
   endtask

   function automatic int m_rem();
      return m_base - m_cyc / CLK_DIV;
   endfunction

   task automatic model_reset();
      m_st = 0; m_base = 0; m_cyc = 0; m_done = 0;
   endtask

   task automatic model_step();
      bit st, sp, dc, ld;
      int ti, r;
      st = bus.start; sp = bus.stop; dc = bus.door_closed; ld = bus.time_load; ti = int'(bus.time_in);
      m_done = 0;
      case (m_st)
         0: if (!sp) begin
               if (ld) begin
                  if (ti != 0) begin m_st = 1; m_base = ti; m_cyc = 0; end
               end
`ifdef TIMER_CTRL_QUICK_START_EN
               else if (st && dc) begin m_st = 2; m_base = QS; m_cyc = 0; end
`endif
            end
         1: if (sp) begin m_st = 0; m_base = 0; m_cyc = 0; end
            else if (ld) begin m_base = ti; m_cyc = 0; if (ti == 0) m_st = 0; end
            else if (st && dc) m_st = 2;
         2: if (sp || !dc) m_st = 3;
            else begin
               r = m_rem();
               m_cyc++;
`ifdef TIMER_CTRL_QUICK_START_EN
               if (st) begin
                  r = r + QS > 255 ? 255 : r + QS;
                  m_base = r + m_cyc / CLK_DIV;
               end else
`endif
               if (m_rem() == 0) begin m_st = 0; m_base = 0; m_cyc = 0; m_done = 1; end
            end
         default:
            if (sp) begin m_st = 0; m_base = 0; m_cyc = 0; end
            else if (st && dc) m_st = 2;
      endcase
   endtask

   initial begin
      drive(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 clear = 1'b0;
      #1;
      chk("reset_state", int'(bus.state), 0);
      chk("reset_rem", int'(bus.remaining), 0);
      chk("reset_done", int'(bus.done), 0);
      chk("reset_mag", int'(bus.magnetron_on), 0);

      add_vec(0, 0, 1, 1, 0, 0, 0, 0);
      add_vec(0, 0, 1, 1, 3, 1, 3, 0);
      add_vec(1, 0, 1, 0, 0, 2, 3, 0);
      for (int k = 1; k <= 13; k++)
         if (k < 12) add_vec(0, 0, 1, 0, 0, 2, 3 - k / 4, 0);
         else        add_vec(0, 0, 1, 0, 0, 0, 0, k == 12);
      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].sp, tbl[i].dc, tbl[i].ld, tbl[i].ti);
         cyc(1);
         chk($sformatf("vec%0d_state", i), int'(bus.state), tbl[i].est);
         chk($sformatf("vec%0d_rem", i), int'(bus.remaining), tbl[i].erem);
         chk($sformatf("vec%0d_done", i), int'(bus.done), int'(tbl[i].edone));
         chk($sformatf("vec%0d_mag", i), int'(bus.magnetron_on), int'(tbl[i].est == 2 && tbl[i].dc));
      end

      drive(0, 0, 1, 1, 5); cyc(1);
      chk("pause_load", int'(bus.state), 1);
      drive(1, 0, 1, 0, 0); cyc(1);
      chk("pause_enter_run", int'(bus.state), 2);
      drive(0, 0, 1, 0, 0); cyc(6);
      chk("pause_rem_before", int'(bus.remaining), 4);
      drive(0, 0, 0, 0, 0); #1;
      chk("pause_mag_same_cycle", int'(bus.magnetron_on), 0);
      chk("pause_state_not_yet", int'(bus.state), 2);
      cyc(1);
      chk("pause_state", int'(bus.state), 3);
      cyc(2);
      chk("pause_rem_held", int'(bus.remaining), 4);
      drive(1, 0, 1, 0, 0); cyc(1);
      chk("resume_state", int'(bus.state), 2);
      chk("resume_mag", int'(bus.magnetron_on), 1);
      drive(0, 0, 1, 0, 0); cyc(1);
      chk("resume_rem_1cyc", int'(bus.remaining), 4);
      cyc(1);
      chk("resume_rem_2cyc", int'(bus.remaining), 3);

      drive(1, 1, 1, 0, 0); cyc(1);
      chk("stop_over_start", int'(bus.state), 3);
      drive(0, 1, 1, 0, 0); cyc(1);
      chk("stop_paused_state", int'(bus.state), 0);
      chk("stop_paused_rem", int'(bus.remaining), 0);

      drive(0, 0, 1, 1, 0); cyc(1);
      chk("load_zero_idle", int'(bus.state), 0);
      drive(1, 0, 1, 0, 0); cyc(1);
`ifdef TIMER_CTRL_QUICK_START_EN
      chk("idle_start_state", int'(bus.state), 2);
      chk("idle_start_rem", int'(bus.remaining), QS);
`else
      chk("idle_start_state", int'(bus.state), 0);
      chk("idle_start_rem", int'(bus.remaining), 0);
`endif
      drive(0, 1, 1, 0, 0); cyc(2);
      chk("back_to_idle", int'(bus.state), 0);

      drive(0, 0, 1, 1, 7); cyc(1);
      drive(1, 0, 1, 0, 0); cyc(1);
      drive(0, 0, 1, 0, 0); cyc(2);
      chk("async_pre_rem", int'(bus.remaining), 7);
      #2 clear = 1'b1;
      #1;
      chk("async_state", int'(bus.state), 0);
      chk("async_rem", int'(bus.remaining), 0);
      chk("async_mag", int'(bus.magnetron_on), 0);
      cyc(1);
      clear = 1'b0;
      model_reset();

      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 92,
               $urandom_range(0, 99) < 12,
               $urandom_range(0, 9) == 0 ? 0 : ($urandom_range(0, 19) == 0 ? $urandom_range(200, 255)
                                                                           : $urandom_range(1, 12)));
         model_step();
         cyc(1);
         chk("rnd_state", int'(bus.state), m_st);
         chk("rnd_rem", int'(bus.remaining), m_rem());
         chk("rnd_done", int'(bus.done), int'(m_done));
         chk("rnd_mag", int'(bus.magnetron_on), int'(m_st == 2 && bus.door_closed));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/timer_controller.md
# timer_controller

Control unit for the entry/timer/control subsystem. Latches a preset time in seconds and runs a non-recycling countdown one tick every CLK_DIV clocks. Sequences start, pause, resume and stop from user inputs and the door sensor, drives the heater enable, and pulses `done` when the count reaches zero. Sits between the keypad/entry logic and the output/display stage.

## Interface
- CLK_DIV, 100: clock cycles per countdown tick (≥2).
- TIME_W, 8: width of the seconds count.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clear  in  1  reset, asynchronous, active-high.
- start  in  1  start/resume request, sampled each cycle.
- stop  in  1  pause/cancel request; has priority over `start`.
- door_closed  in  1  level; 1 = door closed.
- time_load  in  1  latch `time_in` (only in IDLE/READY).
- time_in  in  TIME_W  preset seconds.
- remaining  out  TIME_W  seconds left, registered.
- magnetron_on  out  1  heater enable = (state==RUNNING) & door_closed, combinational.
- done  out  1  one-cycle registered pulse at countdown completion.
- state  out  2  current FSM state.

## Operation
- States: IDLE=0, READY=1, RUNNING=2, PAUSED=3.
- IDLE:
  - time_load & time_in≠0 → READY, remaining=time_in.
  - time_load & time_in==0 → stay.
  - start ignored (see Configuration).
- READY:
  - stop → IDLE, remaining=0.
  - else time_load → reload remaining (time_in==0 → IDLE, remaining=0).
  - else start & door_closed → RUNNING, prescaler=0.
- RUNNING:
  - stop or !door_closed → PAUSED, prescaler held, no decrement that cycle.
  - else on tick: remaining−1.
  - Tick with remaining==1 → remaining=0, done=1, → IDLE.
- PAUSED:
  - stop → IDLE, remaining=0.
  - else start & door_closed → RUNNING, prescaler resumes from held value.
  - time_load ignored.
- Non-recycling: remaining never decrements below 0; no wrap.
- Priority within one cycle: clear > stop > door open > time_load > start > tick.

## Timing
- Reset values: state=IDLE, remaining=0, done=0, prescaler=0; magnetron_on=0 as a consequence.
- Prescaler counts 0..CLK_DIV−1 only in RUNNING with door closed and no stop. The tick is the cycle it equals CLK_DIV−1; it then wraps to 0.
- First decrement occurs CLK_DIV cycles after the edge that enters RUNNING from READY.
- `done` is high for exactly the one cycle in which state first reads IDLE after completion.
- `magnetron_on` falls in the same cycle `door_closed` falls, before the state update.
- `clear` asserted mid-run forces the reset values immediately, without waiting for a clock edge.

## Configuration
- TIMER_CTRL_QUICK_START_EN defined:
  - In IDLE, start & door_closed & !stop → RUNNING with remaining=QUICK_START_SEC, prescaler=0.
  - In RUNNING, start (no stop, door closed) adds QUICK_START_SEC, saturating at 2^TIME_W−1.
- Undefined: start in IDLE and start in RUNNING have no effect.

## Structure
- Package `timer_ctrl_pkg`: state encodings (ST_IDLE..ST_PAUSED) and QUICK_START_SEC=30.
- Sub-module `tick_prescaler`:
  - ports clk, clear, enable, restart, tick; parameter CLK_DIV.
  - Holds its count when enable=0; restart zeroes it.
- The FSM and the remaining register live in timer_controller.

## Test plan
All scenarios use CLK_DIV=4.
- Reset: clear high 2 cycles, then low → state=0, remaining=0, done=0, magnetron_on=0.
- Full run: load 3, start with door closed → RUNNING; remaining=2/1/0 at 4/8/12 cycles after entry; done high one cycle at the 0 edge; state=IDLE; magnetron_on=0.
- Door pause: load 5, run 6 cycles, open door → magnetron_on drops same cycle; PAUSED with remaining=4 held. Close door and start → RUNNING; next decrement after the remaining 2 prescaler cycles.
- Stop priority: stop and start together in RUNNING → PAUSED. Stop in PAUSED → IDLE, remaining=0.
- Edge inputs: time_load with time_in=0 in IDLE → stays IDLE. Start in IDLE without the macro → no change. With the macro → remaining=30, RUNNING.
- Async reset mid-run: clear pulsed between edges in RUNNING with remaining=7 → immediately IDLE, remaining=0, magnetron_on=0.
